// File: rtl/adpll_pi_filter.sv
// adpll_pi_filter: proportional-integral loop filter between the ADPLL phase
// detector and the DCO control-code input. Power-of-two gains, saturating
// anti-windup integrator with fractional bits, saturating output, and a lock
// detector with hysteresis that selects acquisition or tracking gains.
// Optional feature: define ADPLL_GEAR_SHIFT_EN to enable the ACQUIRE/TRACK
// gear shift; otherwise the tracking gain set is used permanently.
module adpll_pi_filter #(
    parameter int unsigned ERROR_WIDTH   = 8,
    parameter int unsigned DCO_CC_WIDTH  = 9,
    parameter int unsigned FRAC_WIDTH    = 3,
    parameter int unsigned KP_SHIFT_ACQ  = 0,
    parameter int unsigned KI_SHIFT_ACQ  = 1,
    parameter int unsigned KP_SHIFT_TRK  = 1,
    parameter int unsigned KI_SHIFT_TRK  = 3,
    parameter int unsigned LOCK_THRESH   = 2,
    parameter int unsigned UNLOCK_THRESH = 8,
    parameter int unsigned LOCK_COUNT    = 16
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_n_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic                           error_valid_i,
    input  logic                           int_hold_i,
    input  logic                           int_clear_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           dco_valid_o,
    output logic                           lock_o,
    output logic                           track_o
);

    localparam int unsigned ACC_WIDTH   = DCO_CC_WIDTH + FRAC_WIDTH;
    localparam int unsigned PROP_WIDTH  = DCO_CC_WIDTH + 1;
    localparam int unsigned SUM_WIDTH   = DCO_CC_WIDTH + 2;
    localparam int unsigned MAG_WIDTH   = ERROR_WIDTH + 1;
    localparam int unsigned CNT_WIDTH   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SHIFT_WIDTH = 5;

`ifdef ADPLL_GEAR_SHIFT_EN
    localparam bit GEAR_EN = 1'b1;
`else
    localparam bit GEAR_EN = 1'b0;
`endif

    // Saturation bounds, one bit wider than the stored value so sums never wrap
    localparam logic signed [ACC_WIDTH:0] ACC_MAX = {2'b00, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] ACC_MIN = {2'b11, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_WIDTH-1:0] OUT_MAX = {3'b000, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] OUT_MIN = {3'b111, {(DCO_CC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ACQUIRE = 1'b0,
        TRACK   = 1'b1
    } state_t;

    state_t                         state;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [PROP_WIDTH-1:0]   prop_r;
    logic [CNT_WIDTH-1:0]           cnt;
    logic                           valid_s1;

    logic [SHIFT_WIDTH-1:0]         kp_shift;
    logic [SHIFT_WIDTH-1:0]         ki_shift;
    logic signed [ERROR_WIDTH-1:0]  err_prop;
    logic signed [PROP_WIDTH-1:0]   prop_next;
    logic signed [ACC_WIDTH-1:0]    err_acc;
    logic signed [ACC_WIDTH-1:0]    err_scaled;
    logic signed [ACC_WIDTH-1:0]    inc;
    logic signed [ACC_WIDTH:0]      acc_sum;
    logic signed [ACC_WIDTH-1:0]    acc_next;
    logic signed [ACC_WIDTH-1:0]    acc_int;
    logic signed [SUM_WIDTH-1:0]    out_sum;
    logic signed [DCO_CC_WIDTH-1:0] dco_next;
    logic signed [MAG_WIDTH-1:0]    err_ext;
    logic [MAG_WIDTH-1:0]           mag;
    logic                           mag_in_lock;
    logic                           mag_unlock;
    logic [CNT_WIDTH-1:0]           cnt_next;
    logic                           cnt_full_next;

    // Gain selection from the current gear
    always_comb begin
        kp_shift = SHIFT_WIDTH'(KP_SHIFT_TRK);
        ki_shift = SHIFT_WIDTH'(KI_SHIFT_TRK);
        if (GEAR_EN && (state == ACQUIRE)) begin
            kp_shift = SHIFT_WIDTH'(KP_SHIFT_ACQ);
            ki_shift = SHIFT_WIDTH'(KI_SHIFT_ACQ);
        end
    end

    // Stage-1 datapath: proportional term and clamped integrator update
    always_comb begin
        err_prop   = error_i >>> kp_shift;
        prop_next  = PROP_WIDTH'(err_prop);
        err_acc    = ACC_WIDTH'(error_i);
        err_scaled = err_acc <<< FRAC_WIDTH;
        inc        = err_scaled >>> ki_shift;
        acc_sum    = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(inc);
        if (acc_sum > ACC_MAX) begin
            acc_next = ACC_MAX[ACC_WIDTH-1:0];
        end else if (acc_sum < ACC_MIN) begin
            acc_next = ACC_MIN[ACC_WIDTH-1:0];
        end else begin
            acc_next = acc_sum[ACC_WIDTH-1:0];
        end
    end

    // Stage-2 datapath: integer part of the integrator plus proportional term
    always_comb begin
        acc_int = acc >>> FRAC_WIDTH;
        out_sum = SUM_WIDTH'(acc_int) + SUM_WIDTH'(prop_r);
        if (out_sum > OUT_MAX) begin
            dco_next = OUT_MAX[DCO_CC_WIDTH-1:0];
        end else if (out_sum < OUT_MIN) begin
            dco_next = OUT_MIN[DCO_CC_WIDTH-1:0];
        end else begin
            dco_next = out_sum[DCO_CC_WIDTH-1:0];
        end
    end

    // Lock-detector magnitude and saturating in-lock counter
    always_comb begin
        err_ext       = MAG_WIDTH'(error_i);
        mag           = err_ext[MAG_WIDTH-1] ? MAG_WIDTH'(-err_ext) : MAG_WIDTH'(err_ext);
        mag_in_lock   = (32'(mag) <= LOCK_THRESH);
        mag_unlock    = (32'(mag) > UNLOCK_THRESH);
        cnt_next      = '0;
        if (mag_in_lock) begin
            cnt_next = (cnt == CNT_WIDTH'(LOCK_COUNT)) ? cnt : cnt + CNT_WIDTH'(1);
        end
        cnt_full_next = (cnt_next == CNT_WIDTH'(LOCK_COUNT));
    end

    // Integrator (clear > hold > update) and proportional register
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc    <= '0;
            prop_r <= '0;
        end else begin
            if (int_clear_i) begin
                acc <= '0;
            end else if (!int_hold_i && error_valid_i) begin
                acc <= acc_next;
            end
            if (error_valid_i) begin
                prop_r <= prop_next;
            end
        end
    end

    // Output stage: one cycle behind the integrator update
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_s1    <= 1'b0;
            dco_valid_o <= 1'b0;
            dco_cc_o    <= '0;
        end else begin
            valid_s1    <= error_valid_i;
            dco_valid_o <= valid_s1;
            if (valid_s1) begin
                dco_cc_o <= dco_next;
            end
        end
    end

    // Lock detector and gear-shift FSM with hysteresis
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= ACQUIRE;
            track_o <= 1'b0;
            cnt     <= '0;
            lock_o  <= 1'b0;
        end else begin
            if (error_valid_i) begin
                cnt    <= cnt_next;
                lock_o <= cnt_full_next;
            end
            if (!GEAR_EN) begin
                state   <= TRACK;
                track_o <= 1'b1;
            end else if (error_valid_i) begin
                if (state == ACQUIRE) begin
                    if (cnt_full_next) begin
                        state   <= TRACK;
                        track_o <= 1'b1;
                    end
                end else begin
                    if (mag_unlock) begin
                        state   <= ACQUIRE;
                        track_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adpll_pi_filter.sv
// tb_adpll_pi_filter: randomized and directed checks of adpll_pi_filter
// against an integer reference model of the loop filter.
module tb_adpll_pi_filter;

`ifdef ADPLL_GEAR_SHIFT_EN
    localparam bit GEAR = 1'b1;
`else
    localparam bit GEAR = 1'b0;
`endif

    logic              gen_clk_i = 1'b0;
    logic              reset_n_i = 1'b0;
    logic signed [7:0] error_i = '0;
    logic              error_valid_i = 1'b0;
    logic              int_hold_i = 1'b0;
    logic              int_clear_i = 1'b0;
    logic signed [8:0] dco_cc_o;
    logic              dco_valid_o;
    logic              lock_o;
    logic              track_o;

    int n_cmp = 0;
    int n_fail = 0;
    logic [11:0] got_v;
    logic [11:0] exp_v;

    // reference model state (plain integers)
    int m_acc, m_prop, m_dco, m_cnt;
    bit m_pend, m_dvalid, m_lock, m_track;

    adpll_pi_filter dut (
        .gen_clk_i    (gen_clk_i),
        .reset_n_i    (reset_n_i),
        .error_i      (error_i),
        .error_valid_i(error_valid_i),
        .int_hold_i   (int_hold_i),
        .int_clear_i  (int_clear_i),
        .dco_cc_o     (dco_cc_o),
        .dco_valid_o  (dco_valid_o),
        .lock_o       (lock_o),
        .track_o      (track_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    function automatic int floor_div2(input int x, input int s);
        int d;
        d = 1 << s;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_prop = 0; m_dco = 0; m_cnt = 0;
        m_pend = 0; m_dvalid = 0; m_lock = 0; m_track = 0;
    endtask

    // One clock edge of the filter, computed from old state
    task automatic model_edge(input bit v, input int e, input bit h, input bit c);
        int kp, ki, mag;
        bit acq;
        m_dvalid = m_pend;
        if (m_pend) m_dco = clamp(floor_div2(m_acc, 3) + m_prop, -256, 255);
        m_pend = v;
        acq = GEAR && !m_track;
        kp = acq ? 0 : 1;
        ki = acq ? 1 : 3;
        if (v) m_prop = floor_div2(e, kp);
        if (c) m_acc = 0;
        else if (!h && v) m_acc = clamp(m_acc + floor_div2(e * 8, ki), -2048, 2047);
        if (v) begin
            mag = (e < 0) ? -e : e;
            m_cnt = (mag <= 2) ? ((m_cnt < 16) ? m_cnt + 1 : 16) : 0;
            m_lock = (m_cnt == 16);
            if (GEAR) begin
                if (!m_track && m_cnt == 16) m_track = 1;
                else if (m_track && mag > 8) m_track = 0;
            end
        end
        if (!GEAR) m_track = 1;
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge
    task automatic cycle(input bit v, input int e, input bit h, input bit c);
        error_valid_i = v;
        error_i = 8'(e);
        int_hold_i = h;
        int_clear_i = c;
        @(posedge gen_clk_i);
        model_edge(v, e, h, c);
        @(negedge gen_clk_i);
        error_valid_i = 1'b0;
        int_hold_i = 1'b0;
        int_clear_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        model_reset();
        repeat (2) @(negedge gen_clk_i);
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        model_reset();
        #1;
        got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
        n_cmp++;
        if (got_v !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async got {dco,valid,lock,track}=%h exp=000", got_v);
        end
        @(negedge gen_clk_i);
        got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
        n_cmp++;
        if (got_v !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_held got {dco,valid,lock,track}=%h exp=000", got_v);
        end
        reset_n_i = 1'b1;
    endtask

    task automatic test_single();
        int exp_dco;
        do_reset();
        exp_dco = GEAR ? 12 : 5;
        cycle(1, 8, 0, 0);
        n_cmp++;
        if (dco_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency got dco_valid=%b exp=0", dco_valid_o);
        end
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (dco_cc_o !== 9'(exp_dco) || dco_valid_o !== 1'b1 || track_o !== !GEAR) begin
            n_fail++;
            $display("FAIL single_value got dco=%0d valid=%b track=%b exp dco=%0d valid=1 track=%b",
                     dco_cc_o, dco_valid_o, track_o, exp_dco, !GEAR);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
            exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL single_idle cyc=%0d got {dco,valid,lock,track}=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 50; i++) begin
            cycle(1, (i < 40) ? 127 : -128, 0, 0);
            got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
            exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL saturation cyc=%0d got {dco,valid,lock,track}=%h exp=%h", i, got_v, exp_v);
            end
            if (i == 39) begin
                n_cmp++;
                if (dco_cc_o !== 9'sd255) begin
                    n_fail++;
                    $display("FAIL saturation_top got dco=%0d exp=255", dco_cc_o);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i < 16) cycle(1, 0, 0, 0);
            else if (i == 16) cycle(1, 5, 0, 0);
            else cycle(1, 9, 0, 0);
            got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
            exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL lock_seq cyc=%0d got {dco,valid,lock,track}=%h exp=%h", i, got_v, exp_v);
            end
            if (i == 14 || i == 15 || i == 16 || i == 17) begin
                n_cmp++;
                if ((i == 14 && (lock_o !== 1'b0 || track_o !== !GEAR)) ||
                    (i == 15 && (lock_o !== 1'b1 || track_o !== 1'b1)) ||
                    (i == 16 && (lock_o !== 1'b0 || track_o !== 1'b1)) ||
                    (i == 17 && (lock_o !== 1'b0 || track_o !== !GEAR))) begin
                    n_fail++;
                    $display("FAIL lock_point cyc=%0d got lock=%b track=%b", i, lock_o, track_o);
                end
            end
        end
    endtask

    task automatic test_hold_clear();
        do_reset();
        cycle(1, 8, 0, 0);
        cycle(1, 8, 1, 0);
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (dco_cc_o !== 9'(GEAR ? 12 : 5) || dco_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_value got dco=%0d valid=%b exp dco=%0d valid=1", dco_cc_o, dco_valid_o, GEAR ? 12 : 5);
        end
        cycle(1, 8, 1, 1);
        cycle(0, 0, 0, 0);
        n_cmp++;
        if (dco_cc_o !== 9'(GEAR ? 8 : 4)) begin
            n_fail++;
            $display("FAIL clear_value got dco=%0d exp=%0d", dco_cc_o, GEAR ? 8 : 4);
        end
        cycle(0, 0, 0, 1);
        cycle(1, -20, 0, 0);
        cycle(0, 0, 0, 0);
        got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
        exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL clear_idle got {dco,valid,lock,track}=%h exp=%h", got_v, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int e, r;
        bit v, h, c;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if ((i / 100) % 2 == 0) begin
                e = (r < 90) ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 24)) - 12;
            end else begin
                e = (r < 50) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 20)) - 10;
            end
            v = ($urandom_range(0, 7) != 0);
            h = ($urandom_range(0, 15) == 0);
            c = ($urandom_range(0, 31) == 0);
            cycle(v, e, h, c);
            got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
            exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc=%0d got {dco,valid,lock,track}=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 60, 0, 0);
        error_valid_i = 1'b1;
        error_i = 8'sd50;
        @(posedge gen_clk_i);
        #2;
        reset_n_i = 1'b0;
        error_valid_i = 1'b0;
        model_reset();
        #1;
        got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
        n_cmp++;
        if (got_v !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid got {dco,valid,lock,track}=%h exp=000", got_v);
        end
        @(negedge gen_clk_i);
        @(negedge gen_clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
            exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
            n_cmp++;
            if (got_v !== exp_v || dco_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d got {dco,valid,lock,track}=%h exp=%h", i, got_v, exp_v);
            end
        end
        cycle(1, -8, 0, 0);
        cycle(0, 0, 0, 0);
        got_v = {dco_cc_o, dco_valid_o, lock_o, track_o};
        exp_v = {9'(m_dco), m_dvalid, m_lock, m_track};
        n_cmp++;
        if (got_v !== exp_v || dco_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_resume got {dco,valid,lock,track}=%h exp=%h", got_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_lock();
        test_hold_clear();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adpll_pi_filter.md
# adpll_pi_filter

Parametrised proportional-integral loop filter for the ADPLL that sits between the phase detector error output and the DCO control-code input. It has programmable power-of-two gains with separate acquisition and tracking gain sets, a saturating anti-windup integrator with a fractional part, a saturating output, and a valid-strobed sample interface. A built-in lock detector with hysteresis drives the gear shift between the two gain sets.

## Interface
- ERROR_WIDTH, 8: signed phase-error width.
- DCO_CC_WIDTH, 9: signed DCO control-code width.
- FRAC_WIDTH, 3: integrator fractional bits. ACC_WIDTH = DCO_CC_WIDTH + FRAC_WIDTH.
- KP_SHIFT_ACQ, 0 / KI_SHIFT_ACQ, 1: acquisition gain shifts (gain = 2^-shift).
- KP_SHIFT_TRK, 1 / KI_SHIFT_TRK, 3: tracking gain shifts.
- LOCK_THRESH, 2: |error| at or below this counts as an in-lock sample.
- UNLOCK_THRESH, 8: |error| above this forces ACQUIRE. Must be ≥ LOCK_THRESH.
- LOCK_COUNT, 16: consecutive in-lock samples required to assert lock.
- gen_clk_i  in  1  filter clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- error_i  in  ERROR_WIDTH  signed phase error, sampled when error_valid_i=1.
- error_valid_i  in  1  one-cycle sample strobe.
- int_hold_i  in  1  freezes the integrator.
- int_clear_i  in  1  synchronous integrator clear.
- dco_cc_o  out  DCO_CC_WIDTH  signed control code (registered).
- dco_valid_o  out  1  one-cycle pulse when dco_cc_o updates.
- lock_o  out  1  lock indicator (registered).
- track_o  out  1  1 = TRACK gain set active.

## Operation
- Gains: kp_shift and ki_shift come from the current state (ACQUIRE → *_ACQ, TRACK → *_TRK).
- Stage 1 (edge where error_valid_i=1):
  - prop_r <= error_i >>> kp_shift, sign-extended to DCO_CC_WIDTH+1.
  - inc = (error_i sign-extended to ACC_WIDTH, <<< FRAC_WIDTH) >>> ki_shift. Shifts are arithmetic, so they floor toward −∞.
  - acc <= clamp(acc + inc) to signed ACC_WIDTH range [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. The sum is computed at ACC_WIDTH+1 bits and never wraps.
- Integrator priority: int_clear_i (acc <= 0) > int_hold_i (acc unchanged) > normal update. Clear and hold take effect on any edge, whether or not a sample is valid. prop_r still updates on a valid sample.
- Stage 2 (edge after stage 1): dco_cc_o <= clamp(acc >>> FRAC_WIDTH + prop_r) to signed DCO_CC_WIDTH; dco_valid_o <= 1 for one cycle.
- Lock detector, updated on valid samples only. mag = |error_i| at ERROR_WIDTH+1 bits, so −2^(ERROR_WIDTH−1) gives 2^(ERROR_WIDTH−1).
  - mag ≤ LOCK_THRESH: cnt increments, saturating at LOCK_COUNT.
  - Otherwise: cnt <= 0.
  - lock_o = (cnt == LOCK_COUNT), registered.
- Gear-shift FSM, two states:
  - ACQUIRE → TRACK on the edge where cnt becomes LOCK_COUNT.
  - TRACK → ACQUIRE on a valid sample with mag > UNLOCK_THRESH.
  - A sample with LOCK_THRESH < mag ≤ UNLOCK_THRESH clears lock_o but leaves the FSM in TRACK (hysteresis).
  - The new gains apply from the next valid sample.

## Timing
- Latency: error_valid_i sampled at edge N → dco_cc_o and dco_valid_o valid after edge N+1.
- Throughput: one sample per cycle. Back-to-back valids are allowed, so dco_valid_o can be high continuously.
- lock_o and track_o change on the same edge as the stage-1 update of the triggering sample.
- Reset (asynchronous, taking effect immediately):
  - dco_cc_o = 0, dco_valid_o = 0, lock_o = 0, track_o = 0.
  - acc = 0, prop_r = 0, cnt = 0, state = ACQUIRE.
- Reset mid-operation discards the in-flight sample. No dco_valid_o pulse follows the release of reset.

## Configuration
- ADPLL_GEAR_SHIFT_EN defined: the FSM operates as described.
- ADPLL_GEAR_SHIFT_EN undefined: the state is fixed at TRACK, track_o = 1 after reset release, and the *_ACQ parameters are unused. The lock detector and lock_o are unchanged.

## Test plan
- Reset, then one valid error_i=+8 in ACQUIRE (defaults): inc=32, acc=32, prop=8 → dco_cc_o=12 with dco_valid_o pulsed two edges after the strobe.
- error_i=+127 every cycle for 40 cycles: acc saturates at 2047 (no wrap), dco_cc_o saturates at +255. Then error_i=−128 (mag 128) moves acc by −512 per sample, with no wrap in either direction.
- 16 valids with error_i=0: lock_o and track_o rise on the 16th. Then error_i=+5: lock_o=0, track_o=1. Then error_i=+9: track_o=0.
- int_hold_i=1 with valid error_i=+8: acc unchanged, dco_cc_o = acc>>>3 + 8. int_clear_i and int_hold_i both high: acc=0.
- Drop reset_n_i between clock edges mid-stream: all outputs 0 immediately. No dco_valid_o after release until a new valid.
- Build without ADPLL_GEAR_SHIFT_EN, reset, valid error_i=+8: inc=8, prop=4 → dco_cc_o=5, track_o=1.
